branch_predictor: RTL and testbench

- Fetch-stage branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Supplies a taken/target prediction for the current fetch PC.
- Receives the resolved branch outcome back from the execute-stage branch resolution logic (PCSel, Eq/Lt evaluation).
- Trains on that outcome and raises a mispredict/redirect to the PC mux and the pipeline flush logic.
- Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 89 ++++++++
 tb/tb_branch_predictor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict detection and branch statistics
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    typedef struct packed {
        logic            valid;
        logic [TW-1:0]   tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
    } entry_t;

    entry_t          tbl_q [ENTRIES];
    entry_t          tbl_d [ENTRIES];
    entry_t          f_ent;
    entry_t          u_ent;
    logic            u_hit;
    logic [1:0]      ctr_n;
    logic [IDX-1:0]  u_idx;
    logic [31:0]     branch_count_q, branch_count_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;

    always_comb begin
        f_ent       = tbl_q[fetch_pc[IDX+1:2]];
        pred_hit    = f_ent.valid && (f_ent.tag == fetch_pc[XLEN-1:IDX+2]);
        pred_taken  = pred_hit && f_ent.ctr[1];
        pred_target = pred_taken ? f_ent.target : fetch_pc + XLEN'(4);
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                      (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
        branch_count_d     = branch_count_q + 32'(upd_valid);
        mispredict_count_d = mispredict_count_q + 32'(mispredict);
    end

    // Training: saturating counter on a hit, allocate weak-taken on a taken miss
    always_comb begin
        u_idx = upd_pc[IDX+1:2];
        u_ent = tbl_q[u_idx];
        u_hit = u_ent.valid && (u_ent.tag == upd_pc[XLEN-1:IDX+2]);
        ctr_n = upd_taken ? ((u_ent.ctr == 2'b11) ? 2'b11 : u_ent.ctr + 2'b01)
                          : ((u_ent.ctr == 2'b00) ? 2'b00 : u_ent.ctr - 2'b01);
        tbl_d = tbl_q;
        if (upd_valid && u_hit) begin
            tbl_d[u_idx].ctr    = ctr_n;
            tbl_d[u_idx].target = upd_taken ? upd_target : u_ent.target;
        end else if (upd_valid && upd_taken) begin
            tbl_d[u_idx] = '{valid: 1'b1, tag: upd_pc[XLEN-1:IDX+2], target: upd_target, ctr: 2'b10};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            tbl_q              <= tbl_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus reset/wrap sequences for branch_predictor
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic        em;
        logic [31:0] ered;
        logic [31:0] ebc;
        logic [31:0] emc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [31:0] fpc, logic uv, logic [31:0] upc, logic ut,
                                logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                                logic eh, logic et, logic [31:0] etgt, logic em,
                                logic [31:0] ered, logic [31:0] ebc, logic [31:0] emc);
        vec_t v;
        v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.uptgt = uptgt; v.eh = eh; v.et = et; v.etgt = etgt; v.em = em; v.ered = ered;
        v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    function automatic vec_t nu(logic [31:0] fpc, logic eh, logic et, logic [31:0] etgt,
                                logic [31:0] ebc, logic [31:0] emc);
        return mk(fpc, 0, 0, 0, 0, 0, 0, eh, et, etgt, 0, 32'h4, ebc, emc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fetch_pc = v.fpc; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
        upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_target = v.uptgt;
    endtask

    initial begin
        vt.push_back(nu(32'h100, 0, 0, 32'h104, 0, 0));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 32'h104, 1, 32'h200, 0, 0));
        vt.push_back(nu(32'h100, 1, 1, 32'h200, 1, 1));
        vt.push_back(mk(32'h100, 1, 32'h100, 0, 0, 1, 32'h200, 1, 1, 32'h200, 1, 32'h104, 1, 1));
        vt.push_back(mk(32'h100, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104, 0, 32'h104, 2, 2));
        vt.push_back(mk(32'h100, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104, 0, 32'h104, 3, 2));
        vt.push_back(mk(32'h100, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104, 0, 32'h104, 4, 2));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 0, 32'h104, 1, 32'h200, 5, 2));
        vt.push_back(nu(32'h100, 1, 0, 32'h104, 6, 3));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 0, 32'h104, 1, 32'h200, 6, 3));
        vt.push_back(nu(32'h100, 1, 1, 32'h200, 7, 4));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 1, 32'h200, 0, 32'h200, 7, 4));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 1, 32'h200, 0, 32'h200, 8, 4));
        vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h280, 1, 32'h200, 1, 1, 32'h200, 1, 32'h280, 9, 4));
        vt.push_back(nu(32'h100, 1, 1, 32'h280, 10, 5));
        vt.push_back(mk(32'h100, 1, 32'h100, 0, 0, 1, 32'h280, 1, 1, 32'h280, 1, 32'h104, 10, 5));
        vt.push_back(nu(32'h100, 1, 1, 32'h280, 11, 6));
        vt.push_back(nu(32'h140, 0, 0, 32'h144, 11, 6));
        vt.push_back(mk(32'h140, 1, 32'h140, 0, 0, 0, 0, 0, 0, 32'h144, 0, 32'h144, 11, 6));
        vt.push_back(nu(32'h100, 1, 1, 32'h280, 12, 6));
        vt.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 0, 0, 32'h144, 1, 32'h300, 12, 6));
        vt.push_back(nu(32'h140, 1, 1, 32'h300, 13, 7));
        vt.push_back(nu(32'h100, 0, 0, 32'h104, 13, 7));
        vt.push_back(nu(32'h142, 1, 1, 32'h300, 13, 7));
        vt.push_back(mk(32'h200, 0, 32'h500, 1, 32'h600, 0, 0, 0, 0, 32'h204, 0, 32'h600, 13, 7));
        vt.push_back(nu(32'h200, 0, 0, 32'h204, 13, 7));
        vt.push_back(nu(32'hFFFF_FFFC, 0, 0, 32'h0, 13, 7));

        rst = 1'b1;
        drive(nu(32'h100, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d hit", i), 32'(pred_hit), 32'(vt[i].eh));
            chk($sformatf("v%0d taken", i), 32'(pred_taken), 32'(vt[i].et));
            chk($sformatf("v%0d target", i), pred_target, vt[i].etgt);
            chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vt[i].em));
            chk($sformatf("v%0d redirect", i), redirect_pc, vt[i].ered);
            chk($sformatf("v%0d branch_count", i), branch_count, vt[i].ebc);
            chk($sformatf("v%0d mispredict_count", i), mispredict_count, vt[i].emc);
        end

        // reset together with a mispredicting update: update discarded, counters cleared
        @(negedge clk);
        rst = 1'b1;
        drive(mk(32'h140, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst_upd mispredict", 32'(mispredict), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(nu(32'h140, 0, 0, 0, 0, 0));
        #1;
        chk("rst_upd hit140", 32'(pred_hit), 32'd0);
        chk("rst_upd target140", pred_target, 32'h144);
        chk("rst_upd branch_count", branch_count, 32'd0);
        chk("rst_upd mispredict_count", mispredict_count, 32'd0);
        fetch_pc = 32'h100;
        #1;
        chk("rst_upd hit100", 32'(pred_hit), 32'd0);

        // branch counter wraps modulo 2^32
        @(negedge clk);
        force dut.branch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.branch_count_q;
        drive(mk(32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("wrap branch_count ffffffff", branch_count, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("wrap branch_count zero", branch_count, 32'd0);
        chk("wrap mispredict_count", mispredict_count, 32'd0);
        upd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
